// File: rtl/sort_pkg.sv
// Shared entry layout for the sort-network consumer: field widths, slice offsets, entry struct, radix helper.
// Field widths can be overridden with the LOG_STREAM_WIDTH/BITS_UNIT_SELECTION/BITS_ROW_IDX/DATA_PRECISION macros.
`ifndef LOG_STREAM_WIDTH
`define LOG_STREAM_WIDTH 4
`endif
`ifndef BITS_UNIT_SELECTION
`define BITS_UNIT_SELECTION 2
`endif
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 6
`endif
`ifndef DATA_PRECISION
`define DATA_PRECISION 8
`endif

package sort_pkg;
  localparam int LOG_STREAM_WIDTH    = `LOG_STREAM_WIDTH;
  localparam int BITS_UNIT_SELECTION = `BITS_UNIT_SELECTION;
  localparam int BITS_ROW_IDX        = `BITS_ROW_IDX;
  localparam int DATA_PRECISION      = `DATA_PRECISION;
  localparam int DATA_WIDTH          = BITS_ROW_IDX + DATA_PRECISION + LOG_STREAM_WIDTH;

  localparam int STREAM_ID_LSB = 0;
  localparam int VALUE_LSB     = STREAM_ID_LSB + LOG_STREAM_WIDTH;
  localparam int ROW_IDX_LSB   = VALUE_LSB + DATA_PRECISION;

  typedef logic [BITS_ROW_IDX-1:0]        row_idx_t;
  typedef logic [DATA_PRECISION-1:0]      value_t;
  typedef logic [LOG_STREAM_WIDTH-1:0]    stream_id_t;
  typedef logic [BITS_UNIT_SELECTION-1:0] unit_t;

  typedef struct packed {
    row_idx_t   row_idx;
    value_t     value;
    stream_id_t stream_id;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [DATA_WIDTH-1:0] d);
    entry_t e;
    e.row_idx   = d[ROW_IDX_LSB +: BITS_ROW_IDX];
    e.value     = d[VALUE_LSB +: DATA_PRECISION];
    e.stream_id = d[STREAM_ID_LSB +: LOG_STREAM_WIDTH];
    return e;
  endfunction

  // The radix selects the destination unit and is the sort key of the stream.
  function automatic unit_t radix(input entry_t e);
    return e.row_idx[BITS_UNIT_SELECTION-1:0];
  endfunction
endpackage

// File: rtl/sorted_run_splitter_if.sv
// Input entry stream and unpacked, run-tagged output stream of sorted_run_splitter.
interface sorted_run_splitter_if
  import sort_pkg::*;
#(
  parameter int RUN_CNT_WIDTH = 8
) ();
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    in_data;
  logic                     in_last;

  logic                     out_valid;
  logic                     out_ready;
  row_idx_t                 out_row_idx;
  value_t                   out_value;
  stream_id_t               out_stream_id;
  unit_t                    out_unit;
  logic                     out_first;
  logic                     out_last;
  logic [RUN_CNT_WIDTH-1:0] out_run_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_row_idx, out_value, out_stream_id,
           out_unit, out_first, out_last, out_run_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_row_idx, out_value, out_stream_id,
           out_unit, out_first, out_last, out_run_len
  );
endinterface

// File: rtl/sorted_run_splitter_run_len_counter.sv
// Saturating run-length counter; next_len is the length the run would have with one more entry.
module run_len_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             incr,
  output logic [WIDTH-1:0] next_len
);
  localparam logic [WIDTH-1:0] MAX_LEN = '1;

  logic [WIDTH-1:0] count;

  assign next_len = (count == MAX_LEN) ? MAX_LEN : count + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= next_len;
    end
  end
endmodule

// File: rtl/sorted_run_splitter.sv
// Splits a radix-sorted entry stream into per-unit runs with first/last marks and run length.
// Optional SORTED_RUN_ORDER_CHECK_EN builds a sticky ordering-error detector on err_order.
module sorted_run_splitter
  import sort_pkg::*;
#(
  parameter int RUN_CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  sorted_run_splitter_if.slave bus,
  output logic                 err_order
);
  logic   hold_v;
  logic   hold_blk_last;
  entry_t hold_entry;
  entry_t in_entry;
  logic   out_v;
  logic   first_pend;
  logic   out_free;
  logic   accept;
  logic   promote;
  logic   run_end;
  logic [RUN_CNT_WIDTH-1:0] run_len_next;

  assign in_entry     = unpack_entry(bus.in_data);
  assign out_free     = !out_v || bus.out_ready;
  assign bus.in_ready = enable && (!hold_v || out_free);
  assign accept       = bus.in_valid && bus.in_ready;
  // A non-final entry needs its successor before it can know whether it closes its run.
  assign promote      = enable && hold_v && out_free && (hold_blk_last || accept);
  assign run_end      = hold_blk_last || (radix(hold_entry) != radix(in_entry));
  assign bus.out_valid = out_v;

  run_len_counter #(.WIDTH(RUN_CNT_WIDTH)) u_run_len_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (promote && run_end),
    .incr     (promote && !run_end),
    .next_len (run_len_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v            <= 1'b0;
      hold_blk_last     <= 1'b0;
      hold_entry        <= '0;
      out_v             <= 1'b0;
      first_pend        <= 1'b1;
      bus.out_row_idx   <= '0;
      bus.out_value     <= '0;
      bus.out_stream_id <= '0;
      bus.out_unit      <= '0;
      bus.out_first     <= 1'b0;
      bus.out_last      <= 1'b0;
      bus.out_run_len   <= '0;
    end else if (enable) begin
      if (accept) begin
        hold_v        <= 1'b1;
        hold_entry    <= in_entry;
        hold_blk_last <= bus.in_last;
      end else if (promote) begin
        hold_v <= 1'b0;
      end

      if (promote) begin
        out_v             <= 1'b1;
        bus.out_row_idx   <= hold_entry.row_idx;
        bus.out_value     <= hold_entry.value;
        bus.out_stream_id <= hold_entry.stream_id;
        bus.out_unit      <= radix(hold_entry);
        bus.out_first     <= first_pend;
        bus.out_last      <= run_end;
        bus.out_run_len   <= run_len_next;
        first_pend        <= run_end;
      end else if (out_v && bus.out_ready) begin
        out_v <= 1'b0;
      end
    end
  end

`ifdef SORTED_RUN_ORDER_CHECK_EN
  logic order_bad;

  // Within a block the stream must strictly ascend by radix, then stream_id.
  assign order_bad = (radix(in_entry) < radix(hold_entry)) ||
                     ((radix(in_entry) == radix(hold_entry)) &&
                      (in_entry.stream_id <= hold_entry.stream_id));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_order <= 1'b0;
    end else if (accept && hold_v && !hold_blk_last && order_bad) begin
      err_order <= 1'b1;
    end
  end
`else
  assign err_order = 1'b0;
`endif
endmodule

// File: tb/tb_sorted_run_splitter.sv
// Scoreboard bench for sorted_run_splitter: random sorted blocks checked against a run-grouping model.
module tb_sorted_run_splitter;
  import sort_pkg::*;

  localparam int RCW     = 3;
  localparam int MAX_LEN = (1 << RCW) - 1;
  localparam int NUM_UNITS = 1 << BITS_UNIT_SELECTION;

  typedef struct {
    entry_t e;
    logic   first;
    logic   last;
    int     run_len;
  } exp_t;

  logic clk;
  logic rst;
  logic enable;
  logic err_order;
  int   ready_mode;
  int   vectors;
  int   miscompares;

  exp_t   sb[$];
  entry_t blk[$];

  sorted_run_splitter_if #(.RUN_CNT_WIDTH(RCW)) bus ();

  sorted_run_splitter #(.RUN_CNT_WIDTH(RCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus),
    .err_order (err_order)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Downstream ready pattern, updated just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on the output pops one expected entry.
  always @(negedge clk) begin : monitor
    exp_t x;
    logic [RCW-1:0] rl;
    unit_t u;
    if (!rst && enable && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL out_unexpected: got row 0x%0h with empty scoreboard, expected no output",
                 bus.out_row_idx);
      end else begin
        x  = sb.pop_front();
        rl = RCW'(x.run_len);
        u  = unit_t'(x.e.row_idx % NUM_UNITS);
        checkOutput("out_entry",
                    64'({bus.out_row_idx, bus.out_value, bus.out_stream_id, bus.out_unit,
                         bus.out_first, bus.out_last, bus.out_run_len}),
                    64'({x.e.row_idx, x.e.value, x.e.stream_id, u, x.first, x.last, rl}));
      end
    end
  end

  // Reference: group consecutive equal-radix entries of the block into runs.
  task automatic modelBlock();
    int cnt = 0;
    for (int i = 0; i < blk.size(); i++) begin
      exp_t x;
      x.e     = blk[i];
      x.first = (cnt == 0);
      cnt++;
      x.last  = (i == blk.size() - 1) ||
                ((blk[i].row_idx % NUM_UNITS) != (blk[i+1].row_idx % NUM_UNITS));
      x.run_len = (cnt > MAX_LEN) ? MAX_LEN : cnt;
      if (x.last) cnt = 0;
      sb.push_back(x);
    end
  endtask

  task automatic applyStimulus(input entry_t e, input logic last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = {e.row_idx, e.value, e.stream_id};
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 500) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL accept_timeout: in_ready=0 for %0d cycles, expected 1", t);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic sendBlock(input logic gaps);
    modelBlock();
    for (int i = 0; i < blk.size(); i++) begin
      if (gaps && i > 0) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      applyStimulus(blk[i], i == blk.size() - 1);
    end
  endtask

  function automatic entry_t mkEntry(input int r, input int sid);
    entry_t e;
    e.row_idx   = row_idx_t'($urandom_range(0, (1 << (BITS_ROW_IDX - BITS_UNIT_SELECTION)) - 1) * NUM_UNITS + r);
    e.value     = value_t'($urandom);
    e.stream_id = stream_id_t'(sid);
    return e;
  endfunction

  task automatic genBlock();
    blk.delete();
    for (int r = 0; r < NUM_UNITS; r++) begin
      int c = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 4);
      int s = $urandom_range(0, (1 << LOG_STREAM_WIDTH) - c);
      for (int j = 0; j < c; j++) blk.push_back(mkEntry(r, s + j));
    end
    if (blk.size() == 0) blk.push_back(mkEntry($urandom_range(0, NUM_UNITS - 1), 0));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d entries pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("rst_err_order", 64'(err_order), 64'(0));
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    ready_mode    = 0;
    rst           = 1'b1;
    enable        = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'(0));
    checkOutput("reset_row_idx", 64'(bus.out_row_idx), 64'(0));
    checkOutput("reset_run_len", 64'(bus.out_run_len), 64'(0));
    checkOutput("reset_first", 64'(bus.out_first), 64'(0));
    checkOutput("reset_err", 64'(err_order), 64'(0));
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'(1));
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Radix 1,1,1,2: the block-last entry shows up two cycles after acceptance.
    blk.delete();
    blk.push_back(mkEntry(1, 0));
    blk.push_back(mkEntry(1, 1));
    blk.push_back(mkEntry(1, 2));
    blk.push_back(mkEntry(2, 0));
    sendBlock(1'b0);
    @(posedge clk);
    #1;
    checkOutput("lat_valid", 64'(bus.out_valid), 64'(1));
    checkOutput("lat_unit", 64'(bus.out_unit), 64'(2));
    checkOutput("lat_first", 64'(bus.out_first), 64'(1));
    checkOutput("lat_last", 64'(bus.out_last), 64'(1));
    checkOutput("lat_run_len", 64'(bus.out_run_len), 64'(1));
    drain();

    blk.delete();
    blk.push_back(mkEntry(3, 5));
    sendBlock(1'b1);
    drain();

    blk.delete();
    for (int j = 0; j < 9; j++) blk.push_back(mkEntry(3, j));
    sendBlock(1'b1);
    drain();

    // enable low freezes a full OUT even while downstream is ready.
    blk.delete();
    for (int j = 0; j < 3; j++) blk.push_back(mkEntry(0, j));
    modelBlock();
    applyStimulus(blk[0], 1'b0);
    applyStimulus(blk[1], 1'b0);
    enable       = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = {blk[2].row_idx, blk[2].value, blk[2].stream_id};
    bus.in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("dis_in_ready", 64'(bus.in_ready), 64'(0));
      checkOutput("dis_out_valid", 64'(bus.out_valid), 64'(1));
    end
    @(posedge clk);
    #1;
    enable = 1'b1;
    applyStimulus(blk[2], 1'b1);
    drain();

    ready_mode = 1;
    for (int b = 0; b < 40; b++) begin
      if (b == 10) begin
        ready_mode = 2;
        fork
          begin
            repeat (6) @(posedge clk);
            ready_mode = 1;
          end
        join_none
      end
      genBlock();
      sendBlock(1'b1);
    end
    drain();
    checkOutput("sorted_err_order", 64'(err_order), 64'(0));
    ready_mode = 0;

`ifdef SORTED_RUN_ORDER_CHECK_EN
    blk.delete();
    blk.push_back(mkEntry(2, 0));
    blk.push_back(mkEntry(1, 0));
    sendBlock(1'b0);
    checkOutput("order_radix_err", 64'(err_order), 64'(1));
    drain();
    checkOutput("order_radix_sticky", 64'(err_order), 64'(1));
    pulseReset();
    blk.delete();
    blk.push_back(mkEntry(1, 3));
    blk.push_back(mkEntry(1, 3));
    sendBlock(1'b0);
    checkOutput("order_sid_err", 64'(err_order), 64'(1));
    drain();
    pulseReset();
`endif

    // Reset with HOLD and OUT both occupied discards them; the next block starts a fresh run.
    ready_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    applyStimulus(mkEntry(2, 1), 1'b0);
    applyStimulus(mkEntry(2, 2), 1'b0);
    @(negedge clk);
    checkOutput("full_in_ready", 64'(bus.in_ready), 64'(0));
    @(posedge clk);
    #1;
    pulseReset();
    ready_mode = 0;
    blk.delete();
    for (int j = 0; j < 3; j++) blk.push_back(mkEntry(2, j + 4));
    sendBlock(1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sorted_run_splitter.md
Name: sorted_run_splitter

Overview:
- Consumer side of the bitonic sort network. Takes the serialized, radix-sorted entry stream {row_idx, value, stream_id}, which is ascending by radix and then by stream_id, as produced by down-comparators.
- Unpacks each entry and tags it with its destination unit (radix = row_idx[BITS_UNIT_SELECTION-1:0]).
- Marks the first and last entry of every equal-radix run and reports the run length, so downstream per-unit accumulators can open and close runs.
- Uses one-entry lookahead buffering; valid/ready on both sides.

Parameters:
- LOG_STREAM_WIDTH, `LOG_STREAM_WIDTH, width of the stream_id field (entry LSBs).
- BITS_UNIT_SELECTION, `BITS_UNIT_SELECTION, radix width (LSBs of row_idx).
- BITS_ROW_IDX, `BITS_ROW_IDX, row index width (entry MSBs).
- DATA_PRECISION, `DATA_PRECISION, value field width.
- DATA_WIDTH, BITS_ROW_IDX+DATA_PRECISION+LOG_STREAM_WIDTH, packed entry width.
- RUN_CNT_WIDTH, 8, run-length counter width (saturating).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global advance; low freezes all state.
- in_valid  in  1  input entry valid.
- in_ready  out  1  input accepted when in_valid&in_ready.
- in_data  in  DATA_WIDTH  packed entry: row_idx MSBs, value middle, stream_id LSBs.
- in_last  in  1  entry is the final one of the current sorted block.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_row_idx  out  BITS_ROW_IDX  unpacked row index.
- out_value  out  DATA_PRECISION  unpacked value.
- out_stream_id  out  LOG_STREAM_WIDTH  unpacked stream id.
- out_unit  out  BITS_UNIT_SELECTION  radix / destination unit.
- out_first  out  1  first entry of a run.
- out_last  out  1  last entry of a run (radix changes next, or block end).
- out_run_len  out  RUN_CNT_WIDTH  entries in run including this one; meaningful when out_last.
- err_order  out  1  sticky ordering error (see Optional Feature).

Behaviour:
- Two registered stages:
  - HOLD: hold_v, hold_data, hold_blk_last.
  - OUT: out_v plus the output fields.
- Output registers drive all out_* directly; there is no combinational in->out path.
- Reset: hold_v=0, out_v=0, first_pend=1, run_cnt=0, err_order=0, all out_* data fields 0.
- out_free = !out_v | out_ready.
- in_ready = enable & (!hold_v | (out_free & !hold_blk_last) | (out_free & hold_blk_last)), which reduces to enable & (!hold_v | out_free).
- Per cycle with enable=1, the HOLD entry is promoted to OUT when hold_v & out_free & (hold_blk_last | input accepted).
- On promotion:
  - out_last = hold_blk_last | (radix(hold) != radix(accepted input)).
  - out_first = first_pend.
  - out_run_len = sat(run_cnt+1).
  - If out_last: first_pend<=1 and run_cnt<=0. Otherwise first_pend<=0 and run_cnt<=sat(run_cnt+1).
- An accepted input loads HOLD (hold_blk_last<=in_last) in the same cycle HOLD is promoted, or into an empty HOLD.
- If OUT is consumed and nothing is promoted, out_v<=0.
- Latency:
  - Non-final entry appears on OUT the cycle after its successor is accepted.
  - Block-last entry appears 2 cycles after acceptance when OUT is free.
- A non-last entry with no successor waits indefinitely in HOLD; this is legal.
- Saturation: run_cnt sticks at 2^RUN_CNT_WIDTH-1 and never wraps.
- Back-to-back blocks: the first entry of a new block may be accepted in the same cycle the previous block-last is promoted.
- out_ready held low: OUT and HOLD stall, in_ready drops once HOLD is full, out_* remain stable.
- enable=0: in_ready=0, no state change, out_valid and fields held.
- rst asserted mid-block: all in-flight entries are discarded; the next accepted entry is treated as out_first.

Optional Feature:
- Macro SORTED_RUN_ORDER_CHECK_EN.
- Enabled: on each acceptance while hold_v & !hold_blk_last, compare hold against the new input. err_order<=1 (sticky until rst) if radix(new)<radix(hold), or if the radices are equal and stream_id(new)<=stream_id(hold).
- Disabled: err_order tied 0 and no comparator logic is built.

Decomposition:
- Shared package sort_pkg: entry field widths, localparam offsets for the row_idx/value/stream_id slices, entry_t packed struct, and radix extraction function.
- Run state update logic, with no submodule, in this module.
- One natural sub-module: run_len_counter (saturating counter with clear/increment, width RUN_CNT_WIDTH).

Test Plan:
- BITS_UNIT_SELECTION=2, out_ready=1, inputs radix 1,1,1,2 (last on 4th):
  - out_first/out_last = 1/0, 0/0, 0/1 (run_len=3), 1/1 (run_len=1, unit=2).
  - 4th entry appears 2 cycles after acceptance.
- out_ready=0 for 5 cycles mid-stream: in_ready drops after HOLD fills, out_* stable, no entry lost or duplicated.
- Single-entry block (in_last on first entry): out_first=1, out_last=1, run_len=1.
- RUN_CNT_WIDTH=2, 5 equal-radix entries then last: out_run_len=3 (saturated) on the final entry.
- With SORTED_RUN_ORDER_CHECK_EN:
  - Radix 2 then 1 → err_order=1 next cycle and stays high until rst.
  - Equal radix with stream_id 3 then 3 → err_order=1.
- rst pulse while HOLD and OUT are full: next cycle out_valid=0; the subsequent entry has out_first=1 and out_run_len counting from 1.
